// File: rtl/multicore_run_ctrl.sv
// Run controller for a multi-core processor: launches the enabled cores, gathers their
// end-of-operation flags and reports completion (all/any mode), timeout or abort.
module multicore_run_ctrl #(
   parameter int unsigned core_count    = 2,
   parameter int unsigned timeout_width = 16,
   parameter int unsigned done_mode     = 0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     abort,
   input  logic [core_count-1:0]    core_enable,
   input  logic [timeout_width-1:0] timeout_limit,
   input  logic [core_count-1:0]    endop_signal,
   output logic [core_count-1:0]    core_start,
   output logic                     busy,
   output logic                     done,
   output logic                     timed_out,
   output logic [core_count-1:0]    done_mask,
   output logic [timeout_width-1:0] cycle_count
);

   localparam bit any_mode = (done_mode != 0);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_RUN,
      S_DONE,
      S_TIMEOUT
   } state_t;

   state_t                   state, state_n;
   logic [core_count-1:0]    en_mask, en_mask_n;
   logic [core_count-1:0]    done_mask_n, core_start_n, mask_upd;
   logic [timeout_width-1:0] limit, limit_n, cycle_count_n, count_upd;
   logic                     complete;

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_n;
   end

   // Next-state and next-register values
   always_comb begin
      state_n       = state;
      en_mask_n     = en_mask;
      limit_n       = limit;
      done_mask_n   = done_mask;
      cycle_count_n = cycle_count;
      core_start_n  = '0;
      mask_upd      = done_mask | (endop_signal & en_mask);
      count_upd     = (&cycle_count) ? cycle_count : cycle_count + timeout_width'(1);
      complete      = any_mode ? (|mask_upd) : (mask_upd == en_mask);

      unique case (state)
         S_IDLE: begin
            if (start) begin
               en_mask_n   = core_enable;
               limit_n     = timeout_limit;
               done_mask_n = '0;
               if (core_enable != '0) begin
                  cycle_count_n = '0;
                  core_start_n  = core_enable;
                  state_n       = S_LAUNCH;
               end else begin
                  state_n = S_DONE;
               end
            end
         end
         S_LAUNCH: state_n = abort ? S_IDLE : S_RUN;
         S_RUN: begin
            // abort freezes mask and counter at their pre-edge values
            if (abort) begin
               state_n = S_IDLE;
            end else begin
               done_mask_n   = mask_upd;
               cycle_count_n = count_upd;
               if (complete) begin
                  state_n = S_DONE;
               end else if ((limit != '0) && (count_upd == limit)) begin
                  state_n = S_TIMEOUT;
               end
            end
         end
         S_DONE, S_TIMEOUT: state_n = S_IDLE;
         default:           state_n = S_IDLE;
      endcase
   end

   // Latched run parameters and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         en_mask     <= '0;
         limit       <= '0;
         done_mask   <= '0;
         cycle_count <= '0;
         core_start  <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         timed_out   <= 1'b0;
      end else begin
         en_mask     <= en_mask_n;
         limit       <= limit_n;
         done_mask   <= done_mask_n;
         cycle_count <= cycle_count_n;
         core_start  <= core_start_n;
         busy        <= (state_n == S_LAUNCH) || (state_n == S_RUN);
         done        <= (state_n == S_DONE);
         timed_out   <= (state_n == S_TIMEOUT);
      end
   end

endmodule

// File: tb/tb_multicore_run_ctrl.sv
// Bench for multicore_run_ctrl: all-mode, any-mode and narrow-counter instances share
// stimulus; each run is predicted from the run rules (end cycle, outcome, final mask/count).
module tb_multicore_run_ctrl;

   localparam int MAXK   = 40;
   localparam int K_NONE = 0;
   localparam int K_DONE = 1;
   localparam int K_TO   = 2;
   localparam int K_AB   = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [1:0]  core_enable = 2'b00;
   logic [1:0]  endop = 2'b00;
   logic [15:0] limit = 16'd0;

   logic [1:0]  cs [3];
   logic [1:0]  dm [3];
   logic        bz [3];
   logic        dn [3];
   logic        to [3];
   logic [15:0] cc [3];
   logic [2:0]  cc_n;
   logic [22:0] obs [3];
   logic [1:0]  ep [0:MAXK+3];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   multicore_run_ctrl #(.core_count(2), .timeout_width(16), .done_mode(0)) dut0 (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .core_enable(core_enable),
      .timeout_limit(limit), .endop_signal(endop), .core_start(cs[0]), .busy(bz[0]),
      .done(dn[0]), .timed_out(to[0]), .done_mask(dm[0]), .cycle_count(cc[0]));

   multicore_run_ctrl #(.core_count(2), .timeout_width(16), .done_mode(1)) dut1 (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .core_enable(core_enable),
      .timeout_limit(limit), .endop_signal(endop), .core_start(cs[1]), .busy(bz[1]),
      .done(dn[1]), .timed_out(to[1]), .done_mask(dm[1]), .cycle_count(cc[1]));

   multicore_run_ctrl #(.core_count(2), .timeout_width(3), .done_mode(0)) dut2 (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .core_enable(core_enable),
      .timeout_limit(limit[2:0]), .endop_signal(endop), .core_start(cs[2]), .busy(bz[2]),
      .done(dn[2]), .timed_out(to[2]), .done_mask(dm[2]), .cycle_count(cc_n));

   assign cc[2] = 16'(cc_n);

   for (genvar g = 0; g < 3; g++) begin : g_obs
      assign obs[g] = {cs[g], bz[g], dn[g], to[g], dm[g], cc[g]};
   end

   // Predict one run: dut 1 is any-mode, dut 2 has a 3-bit limit/counter
   function automatic void model(input int i, input logic [1:0] en, input int lim, input int ab,
                                 output int end_k, output int kind, output logic [1:0] fmask,
                                 output int fcount);
      logic [1:0] acc;
      int         li, sat;
      bit         hit;
      acc    = 2'b00;
      li     = (i == 2) ? lim % 8 : lim;
      sat    = (i == 2) ? 7 : 65535;
      end_k  = MAXK + 1;
      kind   = K_NONE;
      fmask  = 2'b00;
      fcount = 0;
      if (ab == 0) begin
         end_k = 0;
         kind  = K_AB;
      end else begin
         for (int k = 1; k <= MAXK; k++) begin
            if (ab == k) begin
               end_k  = k;
               kind   = K_AB;
               fcount = (k - 1 < sat) ? k - 1 : sat;
               break;
            end
            acc    = acc | (ep[k] & en);
            hit    = (i == 1) ? (acc != 2'b00) : (acc == en);
            fmask  = acc;
            fcount = (k < sat) ? k : sat;
            if (hit) begin
               end_k = k;
               kind  = K_DONE;
               break;
            end
            if (li != 0 && k == li) begin
               end_k = k;
               kind  = K_TO;
               break;
            end
         end
      end
   endfunction

   task automatic clear_ep();
      for (int k = 0; k <= MAXK + 3; k++) ep[k] = 2'b00;
   endtask

   // One launch; ab = -1 none, 0 during LAUNCH, k during RUN cycle k
   task automatic run_one(input string name, input logic [1:0] en, input int lim, input int ab);
      int          end_k [3];
      int          kind [3];
      int          fcnt [3];
      logic [1:0]  fm [3];
      logic [22:0] exp_v;
      logic [1:0]  acc;
      int          last, minend;
      for (int i = 0; i < 3; i++) model(i, en, lim, ab, end_k[i], kind[i], fm[i], fcnt[i]);
      last   = end_k[0];
      minend = end_k[0];
      for (int i = 1; i < 3; i++) begin
         if (end_k[i] > last) last = end_k[i];
         if (end_k[i] < minend) minend = end_k[i];
      end
      start = 1'b1; core_enable = en; limit = 16'(lim); abort = 1'b0; endop = 2'($urandom);
      @(posedge clk); @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         exp_v = {en, 1'b1, 1'b0, 1'b0, 2'b00, 16'd0};
         checks++;
         if (obs[i] !== exp_v)
            $display("FAIL %s launch dut%0d got %h want %h", name, i, obs[i], exp_v);
         if (obs[i] !== exp_v) errors++;
      end
      // parameters change and junk endop arrive while launching
      start = 1'b0; core_enable = 2'($urandom); limit = 16'($urandom); endop = 2'($urandom);
      abort = (ab == 0);
      @(posedge clk); @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         exp_v = (ab == 0) ? 23'd0 : {2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 16'd0};
         checks++;
         if (obs[i] !== exp_v) begin
            errors++;
            $display("FAIL %s run_entry dut%0d got %h want %h", name, i, obs[i], exp_v);
         end
      end
      acc = 2'b00;
      if (ab != 0) begin
         endop = ep[1]; abort = (ab == 1);
         start = (minend >= 1) && ($urandom_range(0, 3) == 0);
         for (int k = 1; k <= last + 1; k++) begin
            @(posedge clk); @(negedge clk);
            acc = acc | (ep[k] & en);
            for (int i = 0; i < 3; i++) begin
               int sat;
               sat = (i == 2) ? 7 : 65535;
               if (k < end_k[i])
                  exp_v = {2'b00, 1'b1, 1'b0, 1'b0, acc, 16'((k < sat) ? k : sat)};
               else if (k == end_k[i])
                  exp_v = {2'b00, 1'b0, 1'(kind[i] == K_DONE), 1'(kind[i] == K_TO), fm[i],
                           16'(fcnt[i])};
               else
                  exp_v = {2'b00, 1'b0, 1'b0, 1'b0, fm[i], 16'(fcnt[i])};
               checks++;
               if (obs[i] !== exp_v) begin
                  errors++;
                  $display("FAIL %s run dut%0d k=%0d got %h want %h", name, i, k, obs[i], exp_v);
               end
            end
            endop = ep[k+1]; abort = (ab == k + 1);
            start = (minend >= k + 1) && ($urandom_range(0, 3) == 0);
         end
      end
      start = 1'b0; abort = 1'b0; endop = 2'b00;
   endtask

   task automatic test_reset();
      #2 reset = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (obs[i] !== 23'd0) begin
            errors++;
            $display("FAIL reset_async dut%0d got %h want 0", i, obs[i]);
         end
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (obs[i] !== 23'd0) begin
            errors++;
            $display("FAIL reset_hold dut%0d got %h want 0", i, obs[i]);
         end
      end
      reset = 1'b1;
   endtask

   task automatic test_all_mode();
      clear_ep(); ep[3] = 2'b01; ep[6] = 2'b10;
      run_one("all_mode", 2'b11, 0, -1);
      checks++;
      if ({dm[0], cc[0]} !== {2'b11, 16'd6}) begin
         errors++;
         $display("FAIL all_mode_final got %b/%0d want 11/6", dm[0], cc[0]);
      end
   endtask

   task automatic test_disabled_core();
      clear_ep();
      for (int k = 0; k <= MAXK + 3; k++) ep[k] = 2'b10;
      run_one("disabled_core", 2'b01, 4, -1);
      checks++;
      if ({dm[0], cc[0]} !== {2'b00, 16'd4}) begin
         errors++;
         $display("FAIL disabled_final got %b/%0d want 00/4", dm[0], cc[0]);
      end
   endtask

   task automatic test_any_mode();
      clear_ep(); ep[2] = 2'b10;
      run_one("any_mode", 2'b11, 0, 10);
      checks++;
      if ({dm[1], cc[1]} !== {2'b10, 16'd2}) begin
         errors++;
         $display("FAIL any_mode_final got %b/%0d want 10/2", dm[1], cc[1]);
      end
   endtask

   task automatic test_done_beats_timeout();
      clear_ep(); ep[1] = 2'b01; ep[3] = 2'b10;
      run_one("tie", 2'b11, 3, -1);
      checks++;
      if ({dm[0], cc[0]} !== {2'b11, 16'd3}) begin
         errors++;
         $display("FAIL tie_final got %b/%0d want 11/3", dm[0], cc[0]);
      end
   endtask

   task automatic test_abort_restart();
      clear_ep(); ep[1] = 2'b01;
      run_one("abort", 2'b11, 0, 2);
      for (int c = 0; c < 3; c++) begin
         endop = 2'($urandom); abort = 1'($urandom);
         @(posedge clk); @(negedge clk);
         checks++;
         if (obs[0] !== {2'b00, 1'b0, 1'b0, 1'b0, 2'b01, 16'd1}) begin
            errors++;
            $display("FAIL abort_idle c=%0d got %h want %h", c, obs[0],
                     {2'b00, 3'b000, 2'b01, 16'd1});
         end
      end
      abort = 1'b0; endop = 2'b00;
      clear_ep(); ep[1] = 2'b11;
      run_one("restart", 2'b11, 0, -1);
   endtask

   task automatic test_zero_enable();
      start = 1'b1; core_enable = 2'b00; limit = 16'd5;
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (obs[i][22:16] !== 7'b0001000) begin
            errors++;
            $display("FAIL zero_en_done dut%0d got %b want 0001000", i, obs[i][22:16]);
         end
      end
      @(posedge clk); @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (obs[i][22:16] !== 7'b0) begin
            errors++;
            $display("FAIL zero_en_after dut%0d got %b want 0", i, obs[i][22:16]);
         end
      end
   endtask

   task automatic test_reset_mid_run();
      logic [22:0] exp_v [4];
      start = 1'b1; core_enable = 2'b11; limit = 16'd0;
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      repeat (2) @(posedge clk);
      #2 reset = 1'b0; start = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (obs[i] !== 23'd0) begin
            errors++;
            $display("FAIL midrun_reset dut%0d got %h want 0", i, obs[i]);
         end
      end
      @(posedge clk); @(negedge clk);
      reset = 1'b1;
      exp_v[0] = {2'b11, 1'b1, 1'b0, 1'b0, 2'b00, 16'd0};
      exp_v[1] = {2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 16'd0};
      exp_v[2] = {2'b00, 1'b0, 1'b1, 1'b0, 2'b11, 16'd1};
      exp_v[3] = {2'b00, 1'b0, 1'b0, 1'b0, 2'b11, 16'd1};
      for (int s = 0; s < 4; s++) begin
         @(posedge clk); @(negedge clk);
         if (s == 0) start = 1'b0;
         endop = (s == 1) ? 2'b11 : 2'b00;
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs[i] !== exp_v[s]) begin
               errors++;
               $display("FAIL midrun_relaunch s=%0d dut%0d got %h want %h", s, i, obs[i],
                        exp_v[s]);
            end
         end
      end
      endop = 2'b00;
   endtask

   task automatic test_random();
      for (int n = 0; n < 150; n++) begin
         int ab;
         for (int k = 0; k <= MAXK + 3; k++)
            ep[k] = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
         ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : 30;
         run_one("random", 2'($urandom_range(1, 3)), int'($urandom_range(0, 15)), ab);
      end
   endtask

   initial begin
      test_reset();
      @(negedge clk);
      test_all_mode();
      test_disabled_core();
      test_any_mode();
      test_done_beats_timeout();
      test_abort_restart();
      test_zero_enable();
      test_reset_mid_run();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/multicore_run_ctrl.md
# multicore_run_ctrl

Parametrised run controller for a `core_count`-core processor. It launches a selected subset of cores with a one-cycle start pulse and collects each core's end-of-operation signal into a sticky mask. It reports completion in all-cores or any-core mode, and aborts on a programmable cycle timeout. It sits between the top-level `start` and the per-core `endop_signal` bus, replacing ad-hoc per-core end detection at the processor top.

## Interface
- `core_count`, 2, number of cores controlled (1..32)
- `timeout_width`, 16, width of timeout limit and cycle counter
- `done_mode`, 0, 0 = complete when all enabled cores ended; 1 = complete when any enabled core ended

- `clk`  in  1  system clock, all state updates on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  run request, sampled in IDLE only
- `abort`  in  1  cancel run, sampled in LAUNCH/RUN
- `core_enable`  in  core_count  cores to launch, latched on accepted start
- `timeout_limit`  in  timeout_width  max RUN cycles; 0 = no timeout; latched on accepted start
- `endop_signal`  in  core_count  per-core end-of-operation level/pulse
- `core_start`  out  core_count  one-cycle launch pulse per enabled core
- `busy`  out  1  high in LAUNCH and RUN
- `done`  out  1  one-cycle completion pulse
- `timed_out`  out  1  one-cycle timeout pulse
- `done_mask`  out  core_count  sticky per-core ended flags for current/last run
- `cycle_count`  out  timeout_width  RUN cycles elapsed, saturating

## Operation
- States: IDLE, LAUNCH, RUN, DONE, TIMEOUT.
- IDLE:
  - `start`=1 with `core_enable`≠0: latch enable mask and limit, clear `done_mask` and `cycle_count`, go to LAUNCH.
  - `start`=1 with `core_enable`=0: go to DONE directly; `done_mask` = 0.
- LAUNCH (1 cycle): `core_start` = latched mask. Go to RUN; `abort` goes to IDLE.
- RUN, per edge:
  - `cycle_count` += 1, saturating at all-ones.
  - `done_mask` |= `endop_signal` & mask. Bits of non-enabled cores are never set.
  - Complete when the updated `done_mask` == mask (mode 0), or when any bit is set (mode 1); go to DONE.
  - Else if limit≠0 and updated `cycle_count` == limit, go to TIMEOUT.
- Priority in RUN: `abort` > completion > timeout. Completion and timeout on the same edge resolve to DONE.
- `abort` in LAUNCH/RUN: go to IDLE, no `done`/`timed_out` pulse, `done_mask`/`cycle_count` hold.
- DONE: `done`=1 for one cycle, then IDLE. TIMEOUT: `timed_out`=1 for one cycle, then IDLE.
- `start` outside IDLE is ignored; no queuing.
- `endop_signal` is ignored outside RUN, including during LAUNCH.
- `done_mask` and `cycle_count` hold in IDLE until the next accepted start.

## Timing
- Reset, asynchronous, active-low: state IDLE; all outputs 0; latched mask and limit 0. Reset mid-run drops `core_start`/`busy` immediately, with no completion pulse.
- `start` accepted at edge T: `core_start` and `busy` high in cycle T..T+1. RUN spans cycles from edge T+1 on.
- `endop_signal` sampled on the first RUN edge (T+2) gives `done` high in the cycle after edge T+2. Minimum start-to-`done` is 3 edges.
- Limit L with no completion: TIMEOUT entered at the L-th RUN edge; `timed_out` high for the following cycle; `cycle_count` = L.
- `busy` falls on the edge entering DONE/TIMEOUT/IDLE. `done` and `busy` are never high together.
- All outputs are registered; no combinational input-to-output paths.

## Test plan
- Reset then `core_enable`=2'b11, limit=0, mode 0; core0 endop at RUN cycle 3, core1 at cycle 6 -> `core_start`=2'b11 for exactly 1 cycle; `done_mask` 01 then 11; `done` pulse after the 6th RUN edge; `cycle_count`=6.
- `core_enable`=2'b01, `endop_signal`=2'b10 held high, limit=4 -> `done_mask` stays 00; `timed_out` pulse; `cycle_count`=4; `done` never asserted.
- mode 1, `core_enable`=2'b11, core1 endop at RUN cycle 2 -> `done` after the 2nd RUN edge; `done_mask`=2'b10.
- Limit=3 with the final endop arriving on RUN edge 3 -> `done` asserted, `timed_out` stays 0.
- `abort` at RUN cycle 2, then a second `start` -> no pulses after the abort; `done_mask`/`cycle_count` cleared on the new start; `core_start` reissued.
- Active-low `reset` asserted mid-RUN with `start` held high through the reset release -> outputs 0 asynchronously; after release the block launches on the first edge with `start`=1.
